// File: rtl/fifo_wr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_pkg
// Description : Shared constants for the FIFO loopback write controller:
//               FSM state encoding and default settle delay.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_wr_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t DELAY = 2'd1;
  localparam state_t WRITE = 2'd2;

  // Settle delay used when the instantiating design does not override it.
  localparam int DLY_CYCLES_DEFAULT = 10;

  // The settle counter only has to reach 255.
  localparam int DLY_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer with synchronous active-high reset.
//               Both stages are exposed so callers can build edge detectors
//               on the first stage against the second.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q0_o,
  output logic [WIDTH-1:0] q1_o
);

  logic [WIDTH-1:0] s0_q;
  logic [WIDTH-1:0] s1_q;

  // Shift the input through two register stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q0_o = s0_q;
  assign q1_o = s1_q;

endmodule
`default_nettype wire

// File: rtl/fifo_wr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr
// Description : FIFO write-side controller. Waits for an almost-empty rising
//               edge, settles for DLY_CYCLES, then writes an incrementing
//               pattern until almost-full. Reports burst length/done.
//               Optional overflow monitor: define FIFO_WR_OVF_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr
  import fifo_wr_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DLY_CYCLES = DLY_CYCLES_DEFAULT,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              almost_empty,
  input  logic              almost_full,
  input  logic              full,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              busy,
  output logic              burst_done,
  output logic [CNT_W-1:0]  burst_len,
  output logic              ovf_err
);

  localparam logic [DLY_CNT_W-1:0] DLY_LAST = DLY_CNT_W'(DLY_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [DLY_CNT_W-1:0]   dly_cnt_q, dly_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic                   done_q, done_d;

  logic                   ae_d0;
  logic                   ae_d1;
  logic                   ae_rise;
  logic [CNT_W-1:0]       cnt_inc;

  sync_2ff #(.WIDTH(1)) u_ae_sync (
    .clk  (clk),
    .rst  (rst),
    .d_i  (almost_empty),
    .q0_o (ae_d0),
    .q1_o (ae_d1)
  );

  assign ae_rise = ae_d0 & ~ae_d1;

  // Word count including the word accepted at this edge; saturates.
  assign cnt_inc = (wr_en_q && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dly_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      wr_en_q   <= wr_en_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      done_q    <= done_d;
    end
  end

  // Next-state decode; ae_rise is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ae_rise) state_d = DELAY;
      DELAY:   if (dly_cnt_q == DLY_LAST) state_d = WRITE;
      WRITE:   if (almost_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs and counters.
  always_comb begin
    dly_cnt_d = dly_cnt_q;
    wr_en_d   = 1'b0;
    data_d    = data_q;
    cnt_d     = cnt_inc;
    len_d     = len_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ae_rise) dly_cnt_d = '0;
      end
      DELAY: begin
        cnt_d     = '0;
        dly_cnt_d = dly_cnt_q + 1'b1;
      end
      WRITE: begin
        if (almost_full) begin
          // The word on the bus this cycle is taken at this edge, so cnt_inc
          // already includes it.
          len_d  = cnt_inc;
          done_d = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          // wr_en_q is low only on the first WRITE cycle of a burst.
          data_d  = wr_en_q ? data_q + 1'b1 : '0;
        end
      end
      default: ;
    endcase
  end

`ifdef FIFO_WR_OVF_CHECK_EN
  logic ovf_q;

  // Sticky overflow: a write was issued while the FIFO reported full.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (wr_en_q && full) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`else
  logic unused_full;
  assign unused_full = full;
  assign ovf_err     = 1'b0;
`endif

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = data_q;
  assign busy         = (state_q != IDLE);
  assign burst_done   = done_q;
  assign burst_len    = len_q;

endmodule
`default_nettype wire

// File: doc/fifo_wr.md
# fifo_wr

Write-side companion of the FIFO read controller in the FIFO loopback test design. It waits for the FIFO to drain to almost-empty, lets the FIFO flags settle for a programmable delay, then writes an incrementing data pattern until the FIFO reports almost-full. The controller shares the FIFO's single clock. It also reports burst statistics for debug.

## Interface
- DATA_W, 8: width of the written data word.
- DLY_CYCLES, 10: settle cycles between the detected almost-empty edge and the write burst; legal range 1..255.
- CNT_W, 16: width of the burst length counter.

- clk  in  1  FIFO write clock; the only clock.
- rst  in  1  Synchronous, active-high reset.
- almost_empty  in  1  FIFO almost-empty flag; passed through a 2-flop synchronizer.
- almost_full  in  1  FIFO almost-full flag; same clock domain, used unsynchronized.
- full  in  1  FIFO full flag; used only by the overflow check.
- fifo_wr_en  out  1  FIFO write enable, registered.
- fifo_wr_data  out  DATA_W  Write data, registered; valid when fifo_wr_en=1.
- busy  out  1  High when state is not IDLE.
- burst_done  out  1  One-cycle pulse when a burst ends.
- burst_len  out  CNT_W  Number of words written in the last completed burst; held until the next burst ends.
- ovf_err  out  1  Sticky overflow flag (see Configuration).

## Operation
- Synchronizer: ae_d0 <= almost_empty; ae_d1 <= ae_d0; ae_rise = ae_d0 & ~ae_d1.
- IDLE
  - On ae_rise, clear dly_cnt and go to DELAY.
  - Otherwise hold. fifo_wr_en=0.
- DELAY
  - dly_cnt increments each cycle.
  - When dly_cnt == DLY_CYCLES-1, go to WRITE. Exactly DLY_CYCLES cycles are spent in DELAY.
- WRITE, evaluated each cycle:
  - If almost_full=1:
    - fifo_wr_en <= 0.
    - burst_len <= word count.
    - burst_done <= 1.
    - Go to IDLE.
  - Else:
    - fifo_wr_en <= 1.
    - fifo_wr_data <= 0 on the first WRITE cycle of a burst, otherwise fifo_wr_data + 1. The add is modulo 2^DATA_W, so the value wraps to 0.
    - Word count increments on every edge where fifo_wr_en=1. It saturates at 2^CNT_W-1.
- ae_rise outside IDLE is ignored. It is not queued.
- If almost_full is already high on the first WRITE cycle, the burst has zero length: fifo_wr_en is never asserted, burst_len=0, and burst_done still pulses.
- The FIFO accepts a word on each rising clk edge where fifo_wr_en=1.

## Timing
- Reset values: fifo_wr_en=0, fifo_wr_data=0, busy=0, burst_done=0, burst_len=0, ovf_err=0, state=IDLE, dly_cnt=0, and both synchronizer flops 0.
- rst asserted mid-burst: every output returns to its reset value at the next clk edge. No partial-burst statistics are recorded.
- almost_empty rises before edge E. ae_rise is high in the cycle after E, and state=DELAY after edge E+1.
- The first fifo_wr_en=1 appears DLY_CYCLES+1 edges after entering DELAY.
- almost_full sampled high at edge N: fifo_wr_en=0 after edge N. The word presented during that cycle was already written at edge N.
- burst_done is high for exactly one cycle, coincident with the return to IDLE. burst_len is valid in that same cycle.

## Configuration
- FIFO_WR_OVF_CHECK_EN defined:
  - ovf_err <= 1 at any edge where fifo_wr_en=1 and full=1.
  - ovf_err clears only on rst.
- Not defined: ovf_err is tied to 0 and full is unused. No other behaviour changes.

## Structure
- Shared package fifo_wr_pkg holds:
  - state encoding localparams: IDLE=2'd0, DELAY=2'd1, WRITE=2'd2.
  - default DLY_CYCLES constant.
- Sub-module sync_2ff: 2-flop synchronizer with synchronous active-high reset. The synchronizer for almost_empty is instantiated from it and is reusable by the read controller.

## Test plan
- Reset, then hold almost_empty=0 for 50 cycles: busy=0 and fifo_wr_en=0 throughout, all outputs 0.
- almost_empty 0->1 with DLY_CYCLES=10, then almost_full rises after 20 writes: fifo_wr_en rises 13 edges after the input edge; data runs 0..19; burst_len=20; burst_done pulses once.
- DATA_W=4 and a 20-word burst: data runs 0..15 then wraps to 0..3.
- almost_full already high when DELAY ends: zero-length burst, burst_len=0, burst_done=1 for one cycle, no write.
- almost_empty toggles during DELAY and WRITE: there is no restart, and exactly one burst occurs.
- With FIFO_WR_OVF_CHECK_EN defined, force full=1 during a write: ovf_err=1 and stays set until rst. rst asserted mid-burst returns all outputs to 0 at the next edge.
